// File: rtl/pwm_duty_seq.sv
// pwm_duty_seq
// Two-channel duty sequencer feeding the LED/fan PWM generator. Each channel
// holds a duty value in tenths of full scale (0..10). CPU configuration
// writes can set the duty directly, start a timed ramp toward a target, or
// start a periodic blink. A shared prescaler produces the sequencer tick.
//
// Optional build macro: PWM_SEQ_BREATHE_EN
//   When defined, BLINK becomes a breathe pattern. The duty rises one step per
//   tick to the peak, holds, falls one step per tick to zero, holds, and
//   then repeats. When undefined, BLINK is a hard on/off toggle and the
//   breathe logic is not built.

module pwm_duty_seq #(
   parameter int TICK_DIV    = 270000,
   parameter int BLINK_TICKS = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cfg_we,
   input  logic       cfg_ch,
   input  logic [1:0] cfg_mode,
   input  logic [3:0] cfg_duty,
   output logic [3:0] ch1_duty,
   output logic [3:0] ch2_duty,
   output logic [1:0] busy
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int BW = $clog2(BLINK_TICKS + 1);
   localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
   localparam logic [3:0]    DUTY_MAX   = 4'd10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RAMP  = 2'd1;
   localparam logic [1:0] ST_BLINK = 2'd2;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_SET   = 2'd1;
   localparam logic [1:0] MODE_RAMP  = 2'd2;
   localparam logic [1:0] MODE_BLINK = 2'd3;

`ifdef PWM_SEQ_BREATHE_EN
   localparam logic [1:0] PH_RISE    = 2'd0;
   localparam logic [1:0] PH_HOLD_HI = 2'd1;
   localparam logic [1:0] PH_FALL    = 2'd2;
   localparam logic [1:0] PH_HOLD_LO = 2'd3;
   localparam logic [1:0] PH_RESET   = PH_RISE;
`else
   localparam logic [1:0] PH_ON    = 2'd0;
   localparam logic [1:0] PH_OFF   = 2'd1;
   localparam logic [1:0] PH_RESET = PH_ON;
`endif

   logic [PW-1:0] preQ;
   logic [PW-1:0] preD;
   logic          tick;
   logic [3:0]    cfgClamp;
   logic [3:0]    chDuty [2];
   logic          chBusy [2];

   assign tick = (preQ == PRE_LAST);

   // Free-running prescaler; configuration writes never disturb it
   always_comb begin
      preD = tick ? '0 : preQ + 1'b1;
   end

   // Prescaler register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         preQ <= '0;
      end else begin
         preQ <= preD;
      end
   end

   // Requested duty is clamped once here and shared by both channels
   always_comb begin
      cfgClamp = (cfg_duty > DUTY_MAX) ? DUTY_MAX : cfg_duty;
   end

   for (genvar c = 0; c < 2; c++) begin : gChan
      localparam logic CH_SEL = (c == 1);

      logic          wrEn;
      logic [1:0]    stateQ;
      logic [1:0]    stateD;
      logic [3:0]    targetQ;
      logic [3:0]    targetD;
      logic [3:0]    dutyQ;
      logic [3:0]    dutyD;
      logic [BW-1:0] blinkCntQ;
      logic [BW-1:0] blinkCntD;
      logic [1:0]    phaseQ;
      logic [1:0]    phaseD;

      assign wrEn = cfg_we && (cfg_ch == CH_SEL);

      // Channel next state: a write always wins over a tick in the same cycle
      always_comb begin
         stateD    = stateQ;
         targetD   = targetQ;
         dutyD     = dutyQ;
         blinkCntD = blinkCntQ;
         phaseD    = phaseQ;
         if (wrEn) begin
            case (cfg_mode)
               MODE_OFF: begin
                  dutyD  = 4'd0;
                  stateD = ST_IDLE;
               end
               MODE_SET: begin
                  dutyD  = cfgClamp;
                  stateD = ST_IDLE;
               end
               MODE_RAMP: begin
                  targetD = cfgClamp;
                  stateD  = (dutyQ == cfgClamp) ? ST_IDLE : ST_RAMP;
               end
               default: begin
                  targetD   = cfgClamp;
                  blinkCntD = '0;
                  stateD    = ST_BLINK;
`ifdef PWM_SEQ_BREATHE_EN
                  dutyD  = 4'd0;
                  phaseD = PH_RISE;
`else
                  dutyD  = cfgClamp;
                  phaseD = PH_ON;
`endif
               end
            endcase
         end else if (tick) begin
            case (stateQ)
               ST_RAMP: begin
                  if (dutyQ < targetQ) begin
                     dutyD = dutyQ + 4'd1;
                  end else if (dutyQ > targetQ) begin
                     dutyD = dutyQ - 4'd1;
                  end
                  if (dutyD == targetQ) begin
                     stateD = ST_IDLE;
                  end
               end
               ST_BLINK: begin
`ifdef PWM_SEQ_BREATHE_EN
                  case (phaseQ)
                     PH_RISE: begin
                        if (dutyQ < targetQ) begin
                           dutyD = dutyQ + 4'd1;
                        end
                        if (dutyD >= targetQ) begin
                           phaseD    = PH_HOLD_HI;
                           blinkCntD = '0;
                        end
                     end
                     PH_HOLD_HI: begin
                        if (blinkCntQ == BLINK_LAST) begin
                           blinkCntD = '0;
                           phaseD    = PH_FALL;
                        end else begin
                           blinkCntD = blinkCntQ + 1'b1;
                        end
                     end
                     PH_FALL: begin
                        if (dutyQ != 4'd0) begin
                           dutyD = dutyQ - 4'd1;
                        end
                        if (dutyD == 4'd0) begin
                           phaseD    = PH_HOLD_LO;
                           blinkCntD = '0;
                        end
                     end
                     default: begin
                        if (blinkCntQ == BLINK_LAST) begin
                           blinkCntD = '0;
                           phaseD    = PH_RISE;
                        end else begin
                           blinkCntD = blinkCntQ + 1'b1;
                        end
                     end
                  endcase
`else
                  if (blinkCntQ == BLINK_LAST) begin
                     blinkCntD = '0;
                     if (phaseQ == PH_ON) begin
                        phaseD = PH_OFF;
                        dutyD  = 4'd0;
                     end else begin
                        phaseD = PH_ON;
                        dutyD  = targetQ;
                     end
                  end else begin
                     blinkCntD = blinkCntQ + 1'b1;
                  end
`endif
               end
               default: begin
                  stateD = stateQ;
               end
            endcase
         end
      end

      // Channel registers
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            stateQ    <= ST_IDLE;
            targetQ   <= '0;
            dutyQ     <= '0;
            blinkCntQ <= '0;
            phaseQ    <= PH_RESET;
         end else begin
            stateQ    <= stateD;
            targetQ   <= targetD;
            dutyQ     <= dutyD;
            blinkCntQ <= blinkCntD;
            phaseQ    <= phaseD;
         end
      end

      assign chDuty[c] = dutyQ;
      assign chBusy[c] = (stateQ == ST_RAMP) && (dutyQ != targetQ);
   end

   assign ch1_duty = chDuty[0];
   assign ch2_duty = chDuty[1];
   assign busy     = {chBusy[1], chBusy[0]};

endmodule

// File: tb/tb_pwm_duty_seq.sv
// tb_pwm_duty_seq
// Self-checking bench for pwm_duty_seq with TICK_DIV=4, BLINK_TICKS=2.
// Directed scenario tasks check fixed expectations; a randomized phase
// compares every cycle against a tick-counting reference model.

module tb_pwm_duty_seq;

   localparam int TICK_DIV    = 4;
   localparam int BLINK_TICKS = 2;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       cfg_we   = 1'b0;
   logic       cfg_ch   = 1'b0;
   logic [1:0] cfg_mode = 2'd0;
   logic [3:0] cfg_duty = 4'd0;
   logic [3:0] ch1_duty;
   logic [3:0] ch2_duty;
   logic [1:0] busy;

   int nCompared   = 0;
   int nMismatched = 0;

   // Reference model state: mode 0 static, 1 ramping, 2 blinking
   int mPre;
   bit mTick;
   int mMode   [2];
   int mDuty   [2];
   int mTarget [2];
   int mTicks  [2];
   int mV;

   pwm_duty_seq #(
      .TICK_DIV    (TICK_DIV),
      .BLINK_TICKS (BLINK_TICKS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_mode (cfg_mode),
      .cfg_duty (cfg_duty),
      .ch1_duty (ch1_duty),
      .ch2_duty (ch2_duty),
      .busy     (busy)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   function automatic int clampDuty(input int v);
      return (v > 10) ? 10 : v;
   endfunction

   // Blink output as a function of the peak and ticks elapsed since the write
   function automatic int blinkDuty(input int peak, input int n);
`ifdef PWM_SEQ_BREATHE_EN
      int p;
      int len;
      int k;
      p   = (peak < 1) ? 1 : peak;
      len = 2 * p + 2 * BLINK_TICKS;
      k   = n % len;
      if (k <= p) return (k < peak) ? k : peak;
      if (k <= p + BLINK_TICKS) return peak;
      if (k <= 2 * p + BLINK_TICKS) return (peak - (k - p - BLINK_TICKS) > 0) ? peak - (k - p - BLINK_TICKS) : 0;
      return 0;
`else
      return (((n / BLINK_TICKS) % 2) == 0) ? peak : 0;
`endif
   endfunction

   // Reference model advanced on every rising edge
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mPre  = 0;
         mTick = 1'b0;
         for (int ch = 0; ch < 2; ch++) begin
            mMode[ch]   = 0;
            mDuty[ch]   = 0;
            mTarget[ch] = 0;
            mTicks[ch]  = 0;
         end
      end else begin
         mTick = (mPre == TICK_DIV - 1);
         mPre  = mTick ? 0 : mPre + 1;
         for (int ch = 0; ch < 2; ch++) begin
            if (cfg_we && int'(cfg_ch) == ch) begin
               mV = clampDuty(int'(cfg_duty));
               case (cfg_mode)
                  2'd0: begin mDuty[ch] = 0;  mMode[ch] = 0; end
                  2'd1: begin mDuty[ch] = mV; mMode[ch] = 0; end
                  2'd2: begin mTarget[ch] = mV; mMode[ch] = (mDuty[ch] == mV) ? 0 : 1; end
                  default: begin
                     mTarget[ch] = mV;
                     mMode[ch]   = 2;
                     mTicks[ch]  = 0;
                     mDuty[ch]   = blinkDuty(mV, 0);
                  end
               endcase
            end else if (mTick) begin
               if (mMode[ch] == 1) begin
                  mDuty[ch] = mDuty[ch] + ((mTarget[ch] > mDuty[ch]) ? 1 : -1);
                  if (mDuty[ch] == mTarget[ch]) mMode[ch] = 0;
               end else if (mMode[ch] == 2) begin
                  mTicks[ch] = mTicks[ch] + 1;
                  mDuty[ch]  = blinkDuty(mTarget[ch], mTicks[ch]);
               end
            end
         end
      end
   end

   // One-cycle configuration write; call and return on a falling edge
   task automatic writeCfg(input logic ch, input logic [1:0] mode, input logic [3:0] duty);
      cfg_ch   = ch;
      cfg_mode = mode;
      cfg_duty = duty;
      cfg_we   = 1'b1;
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   // Advance to the falling edge just after the next tick edge
   task automatic waitTick();
      for (int i = 0; i < TICK_DIV; i++) begin
         @(negedge clk);
         if (mTick) break;
      end
   endtask

   // Advance until the coming rising edge is a tick edge
   task automatic alignBeforeTick();
      for (int i = 0; i < TICK_DIV; i++) begin
         if (mPre == TICK_DIV - 1) break;
         @(negedge clk);
      end
   endtask

   // Outputs held at zero while reset is asserted
   task automatic test_reset();
      repeat (2) @(negedge clk);
      nCompared++;
      if (ch1_duty !== 4'd0) begin nMismatched++; $display("[TB] FAIL reset_ch1: got %0d want 0", ch1_duty); end
      nCompared++;
      if (ch2_duty !== 4'd0) begin nMismatched++; $display("[TB] FAIL reset_ch2: got %0d want 0", ch2_duty); end
      nCompared++;
      if (busy !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b want 00", busy); end
      reset = 1'b0;
   endtask

   // Immediate SET/OFF writes including clamping and channel isolation
   task automatic test_set();
      writeCfg(1'b0, 2'd1, 4'd7);
      nCompared++;
      if (ch1_duty !== 4'd7) begin nMismatched++; $display("[TB] FAIL set_ch1: got %0d want 7", ch1_duty); end
      nCompared++;
      if (ch2_duty !== 4'd0) begin nMismatched++; $display("[TB] FAIL set_ch2_untouched: got %0d want 0", ch2_duty); end
      writeCfg(1'b1, 2'd1, 4'd15);
      nCompared++;
      if (ch2_duty !== 4'd10) begin nMismatched++; $display("[TB] FAIL set_clamp: got %0d want 10", ch2_duty); end
      nCompared++;
      if (ch1_duty !== 4'd7) begin nMismatched++; $display("[TB] FAIL set_ch1_untouched: got %0d want 7", ch1_duty); end
      writeCfg(1'b0, 2'd0, 4'd9);
      nCompared++;
      if (ch1_duty !== 4'd0) begin nMismatched++; $display("[TB] FAIL off_ch1: got %0d want 0", ch1_duty); end
   endtask

   // Upward ramp 2 -> 6 with busy dropping on the final step
   task automatic test_ramp_up();
      writeCfg(1'b0, 2'd1, 4'd2);
      writeCfg(1'b0, 2'd2, 4'd6);
      nCompared++;
      if (ch1_duty !== 4'd2 || busy[0] !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL ramp_start: duty %0d busy %b want duty 2 busy 1", ch1_duty, busy[0]);
      end
      for (int k = 3; k <= 6; k++) begin
         waitTick();
         nCompared++;
         if (ch1_duty !== 4'(k) || busy[0] !== (k != 6)) begin
            nMismatched++;
            $display("[TB] FAIL ramp_step: duty %0d busy %b want duty %0d busy %b", ch1_duty, busy[0], k, (k != 6));
         end
      end
   endtask

   // Reversal mid-ramp, with the reversing write landing in a tick cycle
   task automatic test_ramp_reverse();
      writeCfg(1'b1, 2'd0, 4'd0);
      writeCfg(1'b1, 2'd2, 4'd10);
      repeat (3) waitTick();
      nCompared++;
      if (ch2_duty !== 4'd3 || busy[1] !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL rev_up3: duty %0d busy %b want duty 3 busy 1", ch2_duty, busy[1]);
      end
      alignBeforeTick();
      writeCfg(1'b1, 2'd2, 4'd1);
      nCompared++;
      if (ch2_duty !== 4'd3 || busy[1] !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL rev_write_on_tick: duty %0d busy %b want duty 3 busy 1", ch2_duty, busy[1]);
      end
      for (int k = 2; k >= 1; k--) begin
         waitTick();
         nCompared++;
         if (ch2_duty !== 4'(k) || busy[1] !== (k != 1)) begin
            nMismatched++;
            $display("[TB] FAIL rev_down: duty %0d busy %b want duty %0d busy %b", ch2_duty, busy[1], k, (k != 1));
         end
      end
      waitTick();
      nCompared++;
      if (ch2_duty !== 4'd1) begin nMismatched++; $display("[TB] FAIL rev_settled: got %0d want 1", ch2_duty); end
   endtask

   // BLINK (or breathe) sequence on ch1 with a concurrent ch2 write
   task automatic test_blink();
`ifdef PWM_SEQ_BREATHE_EN
      int exp [11] = '{1, 2, 3, 3, 3, 2, 1, 0, 0, 0, 1};
      writeCfg(1'b0, 2'd3, 4'd3);
      nCompared++;
      if (ch1_duty !== 4'd0) begin nMismatched++; $display("[TB] FAIL breathe_start: got %0d want 0", ch1_duty); end
      for (int i = 0; i < 11; i++) begin
         if (i == 4) begin
            alignBeforeTick();
            writeCfg(1'b1, 2'd1, 4'd4);
            nCompared++;
            if (ch2_duty !== 4'd4) begin nMismatched++; $display("[TB] FAIL breathe_ch2_set: got %0d want 4", ch2_duty); end
         end else begin
            waitTick();
         end
         nCompared++;
         if (ch1_duty !== 4'(exp[i]) || busy[0] !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL breathe_seq: tick %0d duty %0d busy %b want duty %0d busy 0", i + 1, ch1_duty, busy[0], exp[i]);
         end
      end
`else
      int exp [6] = '{5, 0, 0, 5, 5, 0};
      writeCfg(1'b0, 2'd3, 4'd5);
      nCompared++;
      if (ch1_duty !== 4'd5) begin nMismatched++; $display("[TB] FAIL blink_start: got %0d want 5", ch1_duty); end
      for (int i = 0; i < 6; i++) begin
         if (i == 2) begin
            alignBeforeTick();
            writeCfg(1'b1, 2'd1, 4'd4);
            nCompared++;
            if (ch2_duty !== 4'd4) begin nMismatched++; $display("[TB] FAIL blink_ch2_set: got %0d want 4", ch2_duty); end
         end else begin
            waitTick();
         end
         nCompared++;
         if (ch1_duty !== 4'(exp[i])) begin
            nMismatched++;
            $display("[TB] FAIL blink_seq: tick %0d got %0d want %0d", i + 1, ch1_duty, exp[i]);
         end
      end
      writeCfg(1'b0, 2'd3, 4'd0);
      repeat (3) waitTick();
      nCompared++;
      if (ch1_duty !== 4'd0) begin nMismatched++; $display("[TB] FAIL blink_peak0: got %0d want 0", ch1_duty); end
`endif
      writeCfg(1'b0, 2'd1, 4'd9);
      repeat (3) waitTick();
      nCompared++;
      if (ch1_duty !== 4'd9) begin nMismatched++; $display("[TB] FAIL blink_abort: got %0d want 9", ch1_duty); end
   endtask

   // Asynchronous reset mid-ramp, then first tick timing after release
   task automatic test_reset_midramp();
      writeCfg(1'b0, 2'd0, 4'd0);
      writeCfg(1'b0, 2'd2, 4'd10);
      writeCfg(1'b1, 2'd1, 4'd7);
      repeat (2) waitTick();
      #2 reset = 1'b1;
      #1;
      nCompared++;
      if (ch1_duty !== 4'd0 || ch2_duty !== 4'd0 || busy !== 2'b00) begin
         nMismatched++;
         $display("[TB] FAIL async_reset: ch1 %0d ch2 %0d busy %b want 0 0 00", ch1_duty, ch2_duty, busy);
      end
      @(negedge clk);
      reset = 1'b0;
      writeCfg(1'b0, 2'd2, 4'd1);
      for (int i = 0; i < TICK_DIV; i++) begin
         if (i > 0) @(negedge clk);
         nCompared++;
         if (ch1_duty !== ((i == TICK_DIV - 1) ? 4'd1 : 4'd0) || busy[0] !== (i != TICK_DIV - 1)) begin
            nMismatched++;
            $display("[TB] FAIL first_tick: edge %0d duty %0d busy %b", i, ch1_duty, busy[0]);
         end
      end
   endtask

   // Random writes compared against the reference model every cycle
   task automatic test_random();
      logic [1:0] expBusy;
      for (int n = 0; n < 400; n++) begin
         expBusy = {(mMode[1] == 1 && mDuty[1] != mTarget[1]), (mMode[0] == 1 && mDuty[0] != mTarget[0])};
         nCompared++;
         if (ch1_duty !== 4'(mDuty[0])) begin nMismatched++; $display("[TB] FAIL rand_ch1: cycle %0d got %0d want %0d", n, ch1_duty, mDuty[0]); end
         nCompared++;
         if (ch2_duty !== 4'(mDuty[1])) begin nMismatched++; $display("[TB] FAIL rand_ch2: cycle %0d got %0d want %0d", n, ch2_duty, mDuty[1]); end
         nCompared++;
         if (busy !== expBusy) begin nMismatched++; $display("[TB] FAIL rand_busy: cycle %0d got %b want %b", n, busy, expBusy); end
         cfg_we   = ($urandom_range(0, 5) == 0);
         cfg_ch   = 1'($urandom_range(0, 1));
         cfg_mode = 2'($urandom_range(0, 3));
         cfg_duty = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      cfg_we = 1'b0;
   endtask

   // Scenario sequence and summary
   initial begin
      $display("[TB] pwm_duty_seq bench start");
      test_reset();
      test_set();
      test_ramp_up();
      test_ramp_reverse();
      test_blink();
      test_reset_midramp();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/pwm_duty_seq.md
# pwm_duty_seq

Per-channel duty sequencer for the two-channel LED/fan PWM generator. It owns `ch1_duty` and `ch2_duty` (0–10, in tenths of full scale) and drives them from CPU configuration writes. It supports immediate set, timed ramp toward a target, and periodic blink. It sits between the CPU register block and the PWM generator, so the CPU never has to time duty changes in software.

## Interface

**Parameters**
- `TICK_DIV`, default 270000: clk cycles per sequencer tick (10 ms at 27 MHz). Must be ≥ 2.
- `BLINK_TICKS`, default 50: ticks per blink half-period / hold phase. Must be ≥ 1.

**Ports**
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_we`  in  1  single-cycle write strobe; samples `cfg_ch`, `cfg_mode`, `cfg_duty`.
- `cfg_ch`  in  1  target channel: 0 = ch1, 1 = ch2.
- `cfg_mode`  in  2  0 OFF, 1 SET, 2 RAMP, 3 BLINK.
- `cfg_duty`  in  4  target/peak duty; values above 10 are clamped to 10 at write.
- `ch1_duty`  out  4  registered duty to PWM channel 1.
- `ch2_duty`  out  4  registered duty to PWM channel 2.
- `busy`  out  2  bit n high while channel n+1 is ramping toward its target.

## Operation

**Prescaler**
- One shared counter counts 0..`TICK_DIV`-1 and wraps.
- `tick` is internal and true in the cycle where the counter equals `TICK_DIV`-1.
- Configuration writes never reset the counter.

**Per-channel state**
- Registers: mode state, `target[3:0]`, `duty[3:0]`, blink counter, blink phase.
- Channels are fully independent. A write to one channel never alters the other.

**Mode behaviour on `cfg_we`**
- **OFF**: `duty` ← 0; state IDLE.
- **SET**: `duty` ← clamped value; state IDLE.
- **RAMP**: `target` ← clamped value; `duty` is untouched; state RAMP.
  - On each tick, `duty` moves ±1 toward `target`.
  - When `duty == target` the state becomes IDLE. This includes a write where they are already equal: the state goes to IDLE on the write edge with no tick.
- **BLINK**: `target` ← clamped peak; `duty` ← peak; phase ← ON; blink counter ← 0.
  - On each tick the counter increments.
  - When the counter would reach `BLINK_TICKS`, it clears and the phase toggles: ON gives `duty` = peak, OFF gives `duty` = 0.
  - Peak 0 keeps `duty` at 0 while phases still cycle.

**Other rules**
- A write during any ongoing mode aborts it immediately. The new mode starts from the current `duty` (RAMP) or as defined above.
- `busy[n]` is high exactly while channel n+1 is in RAMP and `duty != target`.
- Arithmetic is unsigned 4-bit. `duty` never leaves 0..10.

## Timing

- **Reset (asynchronous)**:
  - Sets `ch1_duty`=0, `ch2_duty`=0, `busy`=0.
  - Sets states IDLE, targets 0, prescaler 0, blink counters 0, phase ON.
- **Reset asserted mid-ramp or mid-blink**: all outputs go to 0 asynchronously. After release the prescaler restarts at 0, so the first tick is in cycle `TICK_DIV`-1 after release.
- **OFF/SET/BLINK writes**: output changes on the clock edge that samples `cfg_we` (1-cycle latency).
- **RAMP step**: `duty` changes on the edge ending the tick cycle. The first step lands between 1 and `TICK_DIV` cycles after the write.
- **Write in a tick cycle**: the write wins. No step or blink count is applied to that channel in that cycle.
- **Full RAMP**: 0→10 takes 10 ticks. `busy` deasserts on the same edge that the final step lands.
- **Blink half-period**: `BLINK_TICKS` ticks. The first ON phase may be up to `TICK_DIV`-1 cycles shorter because of prescaler phase.

## Configuration

- **`PWM_SEQ_BREATHE_EN` defined**: BLINK becomes breathe.
  - Write sets `duty`←0, phase RISE.
  - RISE steps +1 per tick up to peak, then HOLD_HI for `BLINK_TICKS` ticks.
  - FALL steps −1 per tick down to 0, then HOLD_LO for `BLINK_TICKS` ticks, then back to RISE.
  - `busy` is not asserted in breathe.
- **Not defined**: hard ON/OFF toggle as in Operation. Breathe logic is not synthesised.

## Test plan

Bench uses `TICK_DIV`=4, `BLINK_TICKS`=2.

1. Reset high mid-ramp → `ch1_duty`=0, `ch2_duty`=0, `busy`=0 asynchronously. After release, the first tick is at cycle 3.
2. SET ch1 duty 7 → `ch1_duty`=7 on the next edge, `ch2_duty` unchanged. SET ch2 duty 15 → `ch2_duty`=10 (clamp).
3. From `ch1_duty`=2, RAMP target 6 → `busy[0]`=1; duty steps 3,4,5,6 on successive ticks; `busy[0]`=0 on the edge of the 6.
4. RAMP ch2 0→10, then after 3 steps write RAMP target 1 → duty descends 3,2,1 with no step skipped or duplicated. A write in a tick cycle applies no step.
5. BLINK ch1 peak 5 → duty 5 immediately, then toggles 0/5 every 2 ticks. SET ch2 concurrently does not disturb the ch1 phase.
6. With `PWM_SEQ_BREATHE_EN`, BLINK peak 3 → duty sequence 0,1,2,3, hold 2 ticks, then 2,1,0, hold 2 ticks, then repeat.
